// File: rtl/mem_bank_mp_pkg.sv
// Shared definitions for the multi-port scratchpad: FSM encoding and
// helpers for byte-lane counts and packed per-port slice offsets.
package mem_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Number of byte lanes in a data word.
    function automatic int byte_lanes(input int width);
        return width / 8;
    endfunction

    // Low bit of element idx inside a packed vector of w-bit elements.
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/mem_bank_mp_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// wrapping around; produces a one-hot grant and its index.
module rr_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int PTR_W     = 1
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [PTR_W-1:0]     i_ptr,
    output logic [NUM_PORTS-1:0] o_gnt,
    output logic [PTR_W-1:0]     o_idx,
    output logic                 o_any
);

    // Two passes: ports at/after the pointer first, then the wrapped ports below it.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (!o_any && i_req[j] && (j >= int'(i_ptr))) begin
                o_gnt[j] = 1'b1;
                o_idx    = PTR_W'(j);
                o_any    = 1'b1;
            end
        end
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (!o_any && i_req[j] && (j < int'(i_ptr))) begin
                o_gnt[j] = 1'b1;
                o_idx    = PTR_W'(j);
                o_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bank_mp.sv
// Multi-port scratchpad: NUM_PORTS requesters share one WIDTH x DEPTH array
// through a round-robin arbiter. The array is cleared word-by-word after
// reset; every accepted request gets one response READ_LAT cycles later.
module mem_bank_mp #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 64,
    parameter int NUM_PORTS  = 2,
    parameter int READ_LAT   = 1,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                            clk,
    input  logic                            res,
    input  logic [NUM_PORTS-1:0]            req_valid,
    output logic [NUM_PORTS-1:0]            req_ready,
    input  logic [NUM_PORTS-1:0]            req_wr_rd,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*WIDTH-1:0]      req_wdata,
    input  logic [NUM_PORTS*WIDTH/8-1:0]    req_be,
    output logic [NUM_PORTS-1:0]            resp_valid,
    output logic [NUM_PORTS*WIDTH-1:0]      resp_rdata,
    output logic [NUM_PORTS-1:0]            resp_err,
    output logic                            init_done
);
    import mem_pkg::*;

    localparam int LANES = byte_lanes(WIDTH);
    localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_init_ptr;
    logic                  r_done;
    logic [PW-1:0]         r_rr_ptr;
    logic [WIDTH-1:0]      r_mem [DEPTH];

    logic [NUM_PORTS-1:0]  w_gnt;
    logic [PW-1:0]         w_gidx;
    logic                  w_any;
    logic                  w_xfer;
    logic                  w_wr;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [WIDTH-1:0]      w_wdata;
    logic [LANES-1:0]      w_be;
    logic                  w_in_range;
    logic [WIDTH-1:0]      w_rd_word;

    // Response pipeline: {valid, port, err, rdata} per stage.
    logic                  r_vld_p  [READ_LAT];
    logic [PW-1:0]         r_port_p [READ_LAT];
    logic                  r_err_p  [READ_LAT];
    logic [WIDTH-1:0]      r_data_p [READ_LAT];

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PW)
    ) u_arb (
        .i_req (req_valid),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gidx),
        .o_any (w_any)
    );

    // Accept only in RUN and never while reset is held.
    always_comb begin
        req_ready = '0;
        if ((r_state == ST_RUN) && !res && w_any) begin
            req_ready = w_gnt;
        end
    end

    assign w_xfer = |req_ready;

    // Select the granted port's request fields from the packed buses.
    always_comb begin
        w_wr    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        w_be    = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_gnt[p]) begin
                w_wr    = req_wr_rd[p];
                w_addr  = req_addr[slice_lo(p, ADDR_WIDTH) +: ADDR_WIDTH];
                w_wdata = req_wdata[slice_lo(p, WIDTH) +: WIDTH];
                w_be    = req_be[slice_lo(p, LANES) +: LANES];
            end
        end
    end

    assign w_in_range = ({1'b0, w_addr} < (ADDR_WIDTH + 1)'(DEPTH));
    assign w_rd_word  = (w_in_range && !w_wr) ? r_mem[w_addr] : '0;

    // INIT/RUN sequencer; init_done rises with the move to RUN.
    always_ff @(posedge clk) begin
        if (res) begin
            r_state    <= ST_INIT;
            r_init_ptr <= '0;
            r_done     <= 1'b0;
        end else if (r_state == ST_INIT) begin
            r_init_ptr <= r_init_ptr + 1'b1;
            if (r_init_ptr == ADDR_WIDTH'(DEPTH - 1)) begin
                r_state <= ST_RUN;
                r_done  <= 1'b1;
            end
        end
    end

    assign init_done = r_done;

    // Round-robin pointer advances past the granted port on each transfer.
    always_ff @(posedge clk) begin
        if (res) begin
            r_rr_ptr <= '0;
        end else if (w_xfer) begin
            r_rr_ptr <= (w_gidx == PW'(NUM_PORTS - 1)) ? '0 : w_gidx + 1'b1;
        end
    end

    // Array writes: zero fill during INIT, byte-masked writes during RUN.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_init_ptr] <= '0;
        end else if (w_xfer && w_wr && w_in_range) begin
            for (int b = 0; b < LANES; b++) begin
                if (w_be[b]) begin
                    r_mem[w_addr][b*8 +: 8] <= w_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Stage 0 / shift: response valid bits (flushed by reset).
    always_ff @(posedge clk) begin
        if (res) begin
            for (int s = 0; s < READ_LAT; s++) begin
                r_vld_p[s] <= 1'b0;
            end
        end else begin
            r_vld_p[0] <= w_xfer;
            for (int s = 1; s < READ_LAT; s++) begin
                r_vld_p[s] <= r_vld_p[s-1];
            end
        end
    end

    // Stage 0 / shift: response payload (qualified by the valid bits).
    always_ff @(posedge clk) begin
        r_port_p[0] <= w_gidx;
        r_err_p[0]  <= !w_in_range;
        r_data_p[0] <= w_rd_word;
        for (int s = 1; s < READ_LAT; s++) begin
            r_port_p[s] <= r_port_p[s-1];
            r_err_p[s]  <= r_err_p[s-1];
            r_data_p[s] <= r_data_p[s-1];
        end
    end

    // Pipeline tail: route the response to its issuing port.
    always_comb begin
        resp_valid = '0;
        resp_err   = '0;
        resp_rdata = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_vld_p[READ_LAT-1] && (r_port_p[READ_LAT-1] == PW'(p))) begin
                resp_valid[p]                         = 1'b1;
                resp_err[p]                           = r_err_p[READ_LAT-1];
                resp_rdata[slice_lo(p, WIDTH) +: WIDTH] = r_data_p[READ_LAT-1];
            end
        end
    end

endmodule
